maxpool_window_ctrl: RTL

- Sequences the 4-input max-reduction datapath (`find_max_4`) for max-pooling.
- Streams 4-element beats through a valid/ready handshake. Each beat is reduced to one maximum, and a running maximum is accumulated over a configurable number of beats per window.
- Emits one result per window on a registered valid/ready output.
- Runs a programmed number of windows per job, then pulses done. Sits between the activation buffer read port and the pooling writeback.

---
 rtl/npu_pool_pkg.sv | 17 +
 rtl/find_max_4.sv | 28 ++
 rtl/maxpool_window_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/npu_pool_pkg.sv
// Shared types and default sizing for the max-pooling sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npu_pool_pkg;

    // Default window geometry; the top exposes these as overridable parameters.
    localparam int DEF_MAX_BEATS = 16;
    localparam int DEF_MAX_WIN   = 1024;

    // Job sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } pool_state_t;

endpackage

// File: rtl/find_max_4.sv
// Purpose: unsigned maximum of four packed elements (element k at [k*WIDTH +: WIDTH]).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the result with its own handshake.
module find_max_4 #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH*4-1:0] data_array,
    output logic [WIDTH-1:0]   max_val
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic [WIDTH-1:0] e3;
    logic [WIDTH-1:0] m01;
    logic [WIDTH-1:0] m23;

    assign e0 = data_array[0*WIDTH +: WIDTH];
    assign e1 = data_array[1*WIDTH +: WIDTH];
    assign e2 = data_array[2*WIDTH +: WIDTH];
    assign e3 = data_array[3*WIDTH +: WIDTH];

    // Two-level compare tree; ties resolve either way since only the value is used.
    assign m01     = (e0 >= e1) ? e0 : e1;
    assign m23     = (e2 >= e3) ? e2 : e3;
    assign max_val = (m01 >= m23) ? m01 : m23;

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Purpose: reduce 4-element beats to a running max per window, emit one result per window, done per job.
// Latency: result valid 1 cycle after the window's last beat is accepted; done 1 cycle after last result accepted.
// Backpressure: input ready only when the output register is empty or being drained this cycle.
module maxpool_window_ctrl
    import npu_pool_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int MAX_WIN   = DEF_MAX_WIN,
    parameter int BEAT_W    = $clog2(MAX_BEATS + 1),
    parameter int WIN_W     = $clog2(MAX_WIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [BEAT_W-1:0]    i_cfg_beats,
    input  logic [WIN_W-1:0]     i_cfg_windows,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH*4-1:0]   i_data_array,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_result
);

    pool_state_t        state;
    logic [BEAT_W-1:0]  beats_cfg;
    logic [WIN_W-1:0]   wins_cfg;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIDTH-1:0]   acc;

    logic [WIDTH-1:0]   beat_max;
    logic [WIDTH-1:0]   merged_max;
    logic               beat_fire;
    logic               out_fire;
    logic               last_beat;
    logic               last_win;

    find_max_4 #(
        .WIDTH (WIDTH)
    ) u_find_max_4 (
        .data_array (i_data_array),
        .max_val    (beat_max)
    );

    // The first beat of a window seeds the max; later beats fold into the running value.
    assign merged_max = (beat_cnt == '0) ? beat_max
                      : ((acc > beat_max) ? acc : beat_max);

    // Ready tracks the output register so a held result stalls every beat, not just the last.
    assign o_ready   = (state == ST_ACCUM) && (!o_valid || i_ready);
    assign o_busy    = (state != ST_IDLE);
    assign beat_fire = i_valid && o_ready;
    assign out_fire  = o_valid && i_ready;
    assign last_beat = (beat_cnt == beats_cfg - BEAT_W'(1));
    assign last_win  = (win_cnt == wins_cfg - WIN_W'(1));

    // Job sequencer: config latch, beat/window counting, running max and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beats_cfg <= '0;
            wins_cfg  <= '0;
            beat_cnt  <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            // A consumed result empties the register unless a new one loads below.
            if (out_fire) begin
                o_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        beats_cfg <= (i_cfg_beats == '0) ? BEAT_W'(1) : i_cfg_beats;
                        wins_cfg  <= (i_cfg_windows == '0) ? WIN_W'(1) : i_cfg_windows;
                        beat_cnt  <= '0;
                        win_cnt   <= '0;
                        acc       <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            o_result <= merged_max;
                            o_valid  <= 1'b1;
                            beat_cnt <= '0;
                            win_cnt  <= win_cnt + WIN_W'(1);
                            if (last_win) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            acc      <= merged_max;
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
